qpsk_bit_sync: RTL
==================

# qpsk_bit_sync

Receive-side symbol-timing recovery for the QPSK/DPSK modem. The transmitter derives its symbol clock by dividing `clk` by 256. This block does the reverse: it regenerates that symbol clock from transitions on the demodulated serial stream using a first-order digital PLL (early/late phase counter). It outputs a 50 % duty recovered clock, a one-cycle mid-symbol sample strobe, the retimed data bit and a lock flag for the downstream decoder.

## Interface
- `HALF_PERIOD`, 128: `clk` cycles per half symbol; the full symbol is `2*HALF_PERIOD` = 256.
- `DEAD_ZONE`, 2: phase error (cycles) treated as in-phase.
- `LOCK_COUNT`, 8: consecutive in-phase edges required to assert `locked`.

- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `din` in 1: demodulated serial data, asynchronous to symbol phase.
- `clk_rec` out 1: recovered symbol clock, 50 % duty; rising edge at mid-symbol.
- `sample_en` out 1: one-cycle strobe at mid-symbol.
- `dout` out 1: data bit captured at `sample_en`.
- `locked` out 1: phase lock indicator.

## Operation
**Input path**
- `din` passes through a 2-flop synchronizer (`s1`, `s2`), then a third flop `s3`.
- `edge = s2 ^ s3`. All references to "data" below mean `s2`.

**Phase counter `ph`**
- Width is ceil(log2(2*HALF_PERIOD)); 8 bits at default.
- Counts modulo `2*HALF_PERIOD`. The ideal edge position is `ph == 0`.
- With no edge in the cycle, `ph_next = ph + 1` (mod).
- If `edge` is set in a cycle with current value p:
  - In-phase: p <= DEAD_ZONE or p >= 2*HALF_PERIOD-DEAD_ZONE. Normal increment.
  - Early / local ahead: DEAD_ZONE < p < HALF_PERIOD. Retard by holding, so `ph_next = p`.
  - Late / local behind: HALF_PERIOD <= p < 2*HALF_PERIOD-DEAD_ZONE. Advance, so `ph_next = p + 2` (mod `2*HALF_PERIOD`).
- Each correction step is exactly ±1 cycle per edge.

**Outputs**
- `sample_en` is registered. It is high for exactly one cycle after each cycle in which `ph == HALF_PERIOD`.
- `dout` is registered. It loads `s2` in the same cycle `sample_en` is generated, so `dout` updates coincident with the `sample_en` pulse.
- `clk_rec` is registered: `clk_rec <= (ph_next >= HALF_PERIOD)`. This gives exactly `HALF_PERIOD` low and `HALF_PERIOD` high cycles when uncorrected.

**Lock tracking**
- `lock_cnt` counts up to LOCK_COUNT.
- An in-phase edge increments it, saturating.
- An early or late edge clears it to 0.
- No edge means hold.
- `locked` is registered: `locked <= (lock_cnt_next == LOCK_COUNT)`.

## Timing
**Reset**
- On reset, `ph`, `s1`, `s2`, `s3`, `lock_cnt`, `clk_rec`, `sample_en`, `dout` and `locked` all go to 0.
- Assertion mid-operation takes effect immediately (async), with no partial strobe.
- After release, the first `sample_en` occurs `HALF_PERIOD+1` cycles later.

**Latency**
- From `din` toggle to `edge`: 3 `clk` cycles, a fixed offset absorbed into the phase reference.
- The `ph` correction applies in the cycle after `edge`.

**`sample_en` guarantee**
- Exactly one `sample_en` per `ph` wrap; never duplicated, never skipped.
- Holds only occur for p < HALF_PERIOD, so `ph` always reaches HALF_PERIOD.
- Advances only occur for p >= HALF_PERIOD, so HALF_PERIOD is not skipped.

**Boundary cases**
- Wrap: with DEAD_ZONE=0, an advance at p = 2*HALF_PERIOD-1 gives `ph_next = 1`. Skipping 0 is legal.
- Edges on consecutive cycles (glitch): each is evaluated independently. A second out-of-band edge applies a second ±1 step.
- `locked` drops on the cycle after the first out-of-phase edge is registered.
- `clk_rec` period is 256 ± 1 cycle per corrected symbol.

## Test plan
1. Constant `din`=0, 2000 cycles:
   - `sample_en` every 256 cycles, first at cycle 129 after reset release.
   - `clk_rec` is 128 low / 128 high.
   - `locked` stays 0 and `dout` stays 0.
2. Alternating bits, period 256, edges landing at `ph`=1:
   - `locked`=1 after the 8th edge.
   - `dout` reproduces the pattern, delayed by one symbol.
3. Alternating bits offset so edges arrive at `ph`=40:
   - Each edge retards 1; `ph` at the edge decreases 40→39→…→2 (38 steps).
   - `locked` asserts 8 in-phase edges later.
   - No missing `sample_en` throughout.
4. Data period 255 cycles (fast transmitter), random bits:
   - Advances keep edge error within ±(DEAD_ZONE+1).
   - Count of `sample_en` pulses equals symbols sent.
   - BER = 0.
5. `DEAD_ZONE`=0, edge forced at `ph`=255:
   - Next `ph`=1.
   - `sample_en` appears once in that period.
   - `lock_cnt` cleared.
6. Locked link, then `reset_n` pulsed low for 3 cycles mid-symbol:
   - All outputs read 0 during reset.
   - After release, relock occurs following the case-2 sequence.

Source files
------------

// File: rtl/qpsk_bit_sync.sv
// qpsk_bit_sync -- receive symbol-timing recovery for the QPSK/DPSK modem.
//
// Regenerates the transmitter's clk/(2*HALF_PERIOD) symbol clock from
// transitions on the demodulated stream. The loop is a first-order DPLL: a
// modulo phase counter whose nominal +1 step is held (-1) or doubled (+1)
// on each data edge that falls outside the dead zone around ph == 0.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   din        in   demodulated serial data (asynchronous to symbol phase)
//   clk_rec    out  recovered symbol clock, 50 % duty, rises at mid-symbol
//   sample_en  out  one-cycle strobe at mid-symbol
//   dout       out  data bit captured with sample_en
//   locked     out  LOCK_COUNT consecutive in-phase edges seen
module qpsk_bit_sync #(
    parameter int HALF_PERIOD = 128,
    parameter int DEAD_ZONE   = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic clk_rec,
    output logic sample_en,
    output logic dout,
    output logic locked
);

    localparam int PERIOD = 2 * HALF_PERIOD;
    localparam int PW     = $clog2(PERIOD);
    localparam int LW     = $clog2(LOCK_COUNT + 1);

    // One extra bit so PERIOD and PERIOD-DEAD_ZONE are representable and the
    // +2 advance can be wrapped without overflow.
    localparam logic [PW:0] HP_X  = (PW+1)'(HALF_PERIOD);
    localparam logic [PW:0] DZ_X  = (PW+1)'(DEAD_ZONE);
    localparam logic [PW:0] HI_X  = (PW+1)'(PERIOD - DEAD_ZONE);
    localparam logic [PW:0] PER_X = (PW+1)'(PERIOD);
    localparam logic [LW-1:0] LC_X = LW'(LOCK_COUNT);

    logic          s1, s2, s3;
    logic          din_edge;
    logic [PW-1:0] ph, ph_next;
    logic [PW:0]   p_x, step, sum_x;
    logic          in_phase, early;
    logic [LW-1:0] lock_cnt, lock_cnt_next;
    logic          at_mid;

    assign din_edge = s2 ^ s3;
    assign p_x      = {1'b0, ph};
    assign at_mid   = (p_x == HP_X);

    always_comb begin
        in_phase      = (p_x <= DZ_X) || (p_x >= HI_X);
        early         = !in_phase && (p_x < HP_X);
        step          = (PW+1)'(1);
        lock_cnt_next = lock_cnt;
        if (din_edge) begin
            if (in_phase) begin
                if (lock_cnt != LC_X)
                    lock_cnt_next = lock_cnt + LW'(1);
            end else begin
                lock_cnt_next = '0;
                // Early edges only occur below HALF_PERIOD and late ones at or
                // above it, so neither correction can skip the mid-symbol
                // value and the strobe is never lost or doubled.
                step = early ? (PW+1)'(0) : (PW+1)'(2);
            end
        end
        sum_x = p_x + step;
        if (sum_x >= PER_X)
            sum_x = sum_x - PER_X;
        ph_next = sum_x[PW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            ph        <= '0;
            lock_cnt  <= '0;
            clk_rec   <= 1'b0;
            sample_en <= 1'b0;
            dout      <= 1'b0;
            locked    <= 1'b0;
        end else begin
            s1        <= din;
            s2        <= s1;
            s3        <= s2;
            ph        <= ph_next;
            lock_cnt  <= lock_cnt_next;
            clk_rec   <= ({1'b0, ph_next} >= HP_X);
            sample_en <= at_mid;
            if (at_mid)
                dout <= s2;
            locked    <= (lock_cnt_next == LC_X);
        end
    end

endmodule
